// File: rtl/display_mux.sv
// Multiplexed 7-segment display driver: per-digit scan, hex decode, 4-bit PWM dimming, minus sign.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZB_EN.
module display_mux #(
   parameter int DIGIT_NUM      = 8,
   parameter int SUBSTEP_CYCLES = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   load,
   input  logic [DIGIT_NUM*4-1:0] value,
   input  logic                   sign,
   input  logic [3:0]             brightness,
   input  logic                   blank,
   output logic [6:0]             seg,
   output logic [DIGIT_NUM-1:0]   dig_sel,
   output logic                   pending,
   output logic                   frame_start
);

   localparam int SUB_W = (SUBSTEP_CYCLES > 1) ? $clog2(SUBSTEP_CYCLES) : 1;
   localparam int IDX_W = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUBSTEP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGIT_NUM - 1);
   localparam logic [6:0]       MINUS    = 7'b1000000;

   function automatic logic [6:0] decode_digit(input logic [3:0] nib);
      case (nib)
         4'h0: decode_digit = 7'h3F;
         4'h1: decode_digit = 7'h06;
         4'h2: decode_digit = 7'h5B;
         4'h3: decode_digit = 7'h4F;
         4'h4: decode_digit = 7'h66;
         4'h5: decode_digit = 7'h6D;
         4'h6: decode_digit = 7'h7D;
         4'h7: decode_digit = 7'h07;
         4'h8: decode_digit = 7'h7F;
         4'h9: decode_digit = 7'h6F;
         4'hA: decode_digit = 7'h77;
         4'hB: decode_digit = 7'h7C;
         4'hC: decode_digit = 7'h39;
         4'hD: decode_digit = 7'h5E;
         4'hE: decode_digit = 7'h79;
         default: decode_digit = 7'h71;
      endcase
   endfunction

   logic [SUB_W-1:0]       sub_p0;
   logic [3:0]             step_p0;
   logic [IDX_W-1:0]       idx_p0;
   logic                   live;
   logic [DIGIT_NUM*4-1:0] shadow_value, disp_value;
   logic                   shadow_sign, disp_sign;
   logic [3:0]             shadow_bright, disp_bright;
   logic                   boundary, digit_on, lz_blank;
   logic [IDX_W-1:0]       minus_pos;
   logic [3:0]             nib;
   logic [6:0]             glyph;

   assign boundary = (sub_p0 == SUB_LAST) && (step_p0 == 4'd15) && (idx_p0 == IDX_LAST);

   // Stage p0: scan counters (sub-step -> PWM step -> digit index)
   always_ff @(posedge clock) begin
      if (reset) begin
         sub_p0  <= '0;
         step_p0 <= '0;
         idx_p0  <= '0;
      end else if (sub_p0 == SUB_LAST) begin
         sub_p0  <= '0;
         step_p0 <= step_p0 + 4'd1;
         if (step_p0 == 4'd15)
            idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
      end else begin
         sub_p0 <= sub_p0 + SUB_W'(1);
      end
   end

   // A load landing on the boundary skips the shadow copy so it shows next frame.
   always_ff @(posedge clock) begin
      if (reset) begin
         shadow_value  <= '0;
         shadow_sign   <= 1'b0;
         shadow_bright <= '0;
         disp_value    <= '0;
         disp_sign     <= 1'b0;
         disp_bright   <= '0;
         pending       <= 1'b0;
         live          <= 1'b0;
      end else begin
         if (load && boundary) begin
            disp_value  <= value;
            disp_sign   <= sign;
            disp_bright <= brightness;
            pending     <= 1'b0;
         end else if (load) begin
            shadow_value  <= value;
            shadow_sign   <= sign;
            shadow_bright <= brightness;
            pending       <= 1'b1;
         end else if (boundary && pending) begin
            disp_value  <= shadow_value;
            disp_sign   <= shadow_sign;
            disp_bright <= shadow_bright;
            pending     <= 1'b0;
         end
         if (boundary)
            live <= 1'b1;
      end
   end

`ifdef DISPLAY_LZB_EN
   logic [IDX_W-1:0] ms_idx;

   always_comb begin
      ms_idx = '0;
      for (int i = 1; i < DIGIT_NUM; i++)
         if (disp_value[i*4 +: 4] != 4'd0)
            ms_idx = IDX_W'(i);
   end

   assign minus_pos = (ms_idx == IDX_LAST) ? IDX_LAST : ms_idx + IDX_W'(1);
   assign lz_blank  = idx_p0 > ms_idx;
`else
   assign minus_pos = IDX_LAST;
   assign lz_blank  = 1'b0;
`endif

   assign nib      = disp_value[{idx_p0, 2'b00} +: 4];
   assign digit_on = live && !blank && (step_p0 <= disp_bright);
   assign glyph    = (disp_sign && (idx_p0 == minus_pos)) ? MINUS :
                     lz_blank ? 7'd0 : decode_digit(nib);

   // Stage p1: registered segment / digit drive
   always_ff @(posedge clock) begin
      if (reset) begin
         seg         <= '0;
         dig_sel     <= '0;
         frame_start <= 1'b0;
      end else begin
         seg         <= digit_on ? glyph : 7'd0;
         dig_sel     <= digit_on ? (DIGIT_NUM'(1) << idx_p0) : '0;
         frame_start <= boundary;
      end
   end

endmodule
